// File: rtl/instr_rom_responder_pkg.sv
// Shared constants and state encoding for the instruction-memory responder
// and the fetch FSM that drives it.
package instr_rom_responder_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/instr_rom_responder_rom_array.sv
// Program memory: one synchronous write port and a registered read port that
// returns the pre-write contents when both hit the same address on one edge.
module rom_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents survive reset so a program preloaded before reset stays intact.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_rom_responder.sv
// Fixed-latency instruction fetch responder with an instruction register that
// loads from the next response once armed by ir_load.
module instr_rom_responder
  import instr_rom_responder_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ir_load,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              req_dropped
);

  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  state_t            state;
  logic [1:0]        cnt;
  logic              pend;
  logic              accept;
  logic              respond;
  logic [DATA_W-1:0] hold;

  assign accept  = (state == IDLE) && rd_en;
  assign respond = (state == WAIT) && (cnt == 2'd0);

  // The word is captured at acceptance, so later writes cannot alter it.
  rom_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_addr (addr),
    .rd_data (hold)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      busy        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      ir          <= '0;
      ir_valid    <= 1'b0;
      pend        <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      if (rd_en && (state == WAIT)) req_dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (rd_en) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            state       <= IDLE;
            busy        <= 1'b0;
            rdata       <= hold;
            rdata_valid <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // A response consumes an arm already pending or arriving on the same edge.
      if (respond && (pend || ir_load)) begin
        ir       <= hold;
        ir_valid <= 1'b1;
        pend     <= 1'b0;
      end else if (ir_load) begin
        pend     <= 1'b1;
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_rom_responder.sv
// Scoreboard bench for instr_rom_responder at the default LATENCY of 2.
module tb_instr_rom_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              ir_load = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              req_dropped;

  instr_rom_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .addr        (addr),
    .ir_load     (ir_load),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .req_dropped (req_dropped)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_push = 0;
  int n_pulse = 0;
  logic [DATA_W-1:0] mem_m [256];
  logic [DATA_W-1:0] sb [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_read(input logic [ADDR_W-1:0] a);
    sb.push_back(mem_m[a]);
    n_push++;
  endtask

  // Every response pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdata_valid) begin
      n_pulse++;
      if (sb.size() == 0) check("unexpected_valid", 64'(rdata_valid), 64'(0));
      else check("sb_rdata", 64'(rdata), 64'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Preload while reset is held; memory is not cleared by reset.
    step();
    wr_en = 1'b1;
    wr_addr = 8'h05; wr_data = 16'hBEEF; mem_m[8'h05] = 16'hBEEF;
    step();
    for (int i = 0; i < 4; i++) begin
      wr_addr = ADDR_W'(i); wr_data = DATA_W'(16'h1000 + i); mem_m[i] = DATA_W'(16'h1000 + i);
      step();
    end
    wr_en = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_outs", 64'({busy, rdata_valid, ir_valid, req_dropped, rdata, ir}), 64'(0));
    end

    // Single read, latency 2.
    rd_en = 1'b1; addr = 8'h05; push_read(8'h05);
    step();
    check("e0_busy", 64'(busy), 64'(1));
    check("e0_valid", 64'(rdata_valid), 64'(0));
    rd_en = 1'b0;
    step();
    check("e1_busy", 64'(busy), 64'(1));
    check("e1_valid", 64'(rdata_valid), 64'(0));
    step();
    check("e2_valid", 64'(rdata_valid), 64'(1));
    check("e2_busy", 64'(busy), 64'(0));
    check("e2_rdata", 64'(rdata), 64'(16'hBEEF));
    step();
    check("e3_valid", 64'(rdata_valid), 64'(0));
    check("e3_rdata_hold", 64'(rdata), 64'(16'hBEEF));

    // Back-to-back fetches with the instruction register armed.
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; ir_load = 1'b1; addr = ADDR_W'(i); push_read(ADDR_W'(i));
      step();
      check("fetch_armed_ir_valid", 64'(ir_valid), 64'(0));
      rd_en = 1'b0; ir_load = 1'b0;
      step();
      check("fetch_wait_ir_valid", 64'(ir_valid), 64'(0));
      step();
      check("fetch_ir", 64'(ir), 64'(16'h1000 + i));
      check("fetch_ir_valid", 64'(ir_valid), 64'(1));
      check("fetch_valid", 64'(rdata_valid), 64'(1));
    end

    // Request while busy is dropped and flagged.
    rd_en = 1'b1; addr = 8'h00; push_read(8'h00);
    step();
    addr = 8'h09;
    step();
    rd_en = 1'b0;
    check("drop_flag", 64'(req_dropped), 64'(1));
    check("drop_no_valid", 64'(rdata_valid), 64'(0));
    step();
    check("drop_orig_rdata", 64'(rdata), 64'(16'h1000));
    check("drop_orig_valid", 64'(rdata_valid), 64'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_no_extra", 64'(rdata_valid), 64'(0));
      check("drop_sticky", 64'(req_dropped), 64'(1));
    end

    // Writes at acceptance and during WAIT do not affect the in-flight word.
    rd_en = 1'b1; addr = 8'h05; push_read(8'h05);
    wr_en = 1'b1; wr_addr = 8'h05; wr_data = 16'h2222; mem_m[8'h05] = 16'h2222;
    step();
    rd_en = 1'b0; wr_data = 16'h3333; mem_m[8'h05] = 16'h3333;
    step();
    wr_en = 1'b0;
    step();
    check("wr_inflight_rdata", 64'(rdata), 64'(16'hBEEF));
    rd_en = 1'b1; addr = 8'h05; push_read(8'h05);
    step();
    rd_en = 1'b0;
    step();
    step();
    check("wr_next_rdata", 64'(rdata), 64'(16'h3333));

    // Reset one cycle after acceptance discards the request.
    rd_en = 1'b1; addr = 8'h01;
    step();
    rd_en = 1'b0;
    check("rst_pre_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ir", 64'(ir), 64'(0));
    check("rst_dropped", 64'(req_dropped), 64'(0));
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_valid", 64'(rdata_valid), 64'(0));
    end
    rd_en = 1'b1; ir_load = 1'b1; addr = 8'h02; push_read(8'h02);
    step();
    rd_en = 1'b0; ir_load = 1'b0;
    step();
    check("post_rst_e1_valid", 64'(rdata_valid), 64'(0));
    step();
    check("post_rst_e2_valid", 64'(rdata_valid), 64'(1));
    check("post_rst_ir", 64'(ir), 64'(16'h1002));
    step();

    check("sb_drained", 64'(sb.size()), 64'(0));
    check("pulse_count", 64'(n_pulse), 64'(n_push));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_rom_responder.md
Name: instr_rom_responder

Overview:
Instruction-memory responder on the far side of the fetch interface driven by the control FSM. It accepts a read request (rd_en plus addr, i.e. pc) and returns the instruction word after a fixed latency, with a valid pulse. It also owns the instruction register: an ir_load request is held pending until the returned data arrives, then the data is latched into ir. A write port preloads program contents for bring-up and test.

Parameters:
ADDR_W, 8, address width; matches the pc width.
DATA_W, 16, instruction word width.
LATENCY, 2, cycles from request acceptance to response; legal range 1..4.

Ports:
clk  in  1  clock
reset  in  1  reset
rd_en  in  1  read request from fetch FSM
addr  in  ADDR_W  read address (pc)
ir_load  in  1  arm instruction-register load
wr_en  in  1  program-write strobe
wr_addr  in  ADDR_W  program-write address
wr_data  in  DATA_W  program-write data
busy  out  1  request in flight; new rd_en is ignored
rdata  out  DATA_W  returned instruction word; holds its value between responses
rdata_valid  out  1  one-cycle pulse when rdata is updated
ir  out  DATA_W  instruction register
ir_valid  out  1  ir holds a freshly loaded word since the last arm
req_dropped  out  1  sticky flag: rd_en arrived while busy

Behaviour:
- Reset (reset asynchronous, active-high; clock clk):
  - Clears busy, rdata, rdata_valid, ir, ir_valid, req_dropped, the pending-load flag, the latency counter and the state (to IDLE).
  - Does NOT clear the memory array.
- Memory: 2^ADDR_W words, one synchronous write per cycle (wr_en), independent of read state.
- States:
  - IDLE: rd_en sampled high at edge t accepts the request, reads mem[addr] into a hold register (read-before-write), loads the counter with LATENCY-1 and moves to WAIT. busy=1 from after edge t.
  - WAIT: the counter decrements each edge. On the edge where the count is 0, which is edge t+LATENCY, rdata takes the held word, rdata_valid=1 for exactly one cycle, busy=0, and the state returns to IDLE.
  - LATENCY=1: WAIT lasts one cycle. rdata_valid is visible in the cycle after edge t+1.
- Back-to-back: rd_en may be accepted at the same edge rdata_valid drops, because the state is already IDLE. Minimum request spacing is LATENCY+1 edges.
- rd_en while busy: the request is ignored, no response is generated, req_dropped=1. req_dropped clears only on reset.
- Write during WAIT to the in-flight address: does not change the returned word, because data is captured at acceptance.
- Write and accept at the same edge, same address: the read returns the old word and memory takes the new word.
- ir_load:
  - Sampled high at an edge, it sets pend=1 and ir_valid=0.
  - On the response edge with pend=1: ir takes the returned word, ir_valid=1, pend=0.
  - If ir_load and the response coincide at the same edge, the response loads ir and pend stays clear, i.e. load wins.
  - On a response with pend=0, ir is unchanged.
  - A second ir_load while pend=1 has no further effect.
- Reset mid-operation: the in-flight request is discarded, no rdata_valid pulse, pend cleared.
- addr/wr_addr are full-width, so there are no out-of-range cases. The internal counter is 2 bits, sized for LATENCY<=4.

Decomposition:
- Shared package: state encoding (IDLE, WAIT), LATENCY_MIN=1, LATENCY_MAX=4, and the default ADDR_W/DATA_W constants shared with the fetch FSM.
- One sub-module: rom_array (parameterised ADDR_W/DATA_W; synchronous write; registered read-before-write port).
- The responder FSM, counter and IR logic stay in the top module.

Test Plan:
- Reset then idle: all outputs 0 and busy=0 for 5 cycles; the memory preload written before reset still reads back afterwards.
- Preload mem[0x05]=0xBEEF, LATENCY=2: rd_en+addr=0x05 at edge 0 -> busy=1 after edges 0..1; rdata=0xBEEF and rdata_valid=1 only after edge 2; busy=0 after edge 2.
- FSM-style fetch, pc=0..3 with contents 0x1000+i: ir_load with rd_en -> ir=0x1000+i and ir_valid=1 after each response edge; ir_valid=0 between the arm and the response.
- rd_en reasserted while busy with addr=0x09 -> no extra rdata_valid pulse, req_dropped=1 and stays 1; the original response is still correct.
- Write 0x2222 to 0x05 at the acceptance edge, then 0x3333 during WAIT -> response 0xBEEF; the next read of 0x05 returns 0x3333.
- Reset asserted one cycle after acceptance -> no rdata_valid pulse ever for that request; busy=0 immediately; ir=0; the next read works with the nominal latency.
